// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// Optional macro BCD_SIGN_EN adds a sign_i input and two's-complement output.
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_i,
`ifdef BCD_SIGN_EN
  input  logic                sign_i,
`endif
  output logic                busy,
  output logic                valid,
  output logic                error,
  output logic [BIN_W:0]      binario
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             r_state, w_state_next;
  logic [BCD_W-1:0]   r_bcd, w_bcd_next;
  logic [BIN_W-1:0]   r_bin, w_bin_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic               w_busy_next, w_valid_next, w_error_next;
  logic [BIN_W:0]     w_binario_next;
  logic               w_bad_digit;
  logic [BCD_W+BIN_W-1:0] w_cat;
  logic [BCD_W-1:0]   w_bcd_corr;
  logic [BIN_W-1:0]   w_bin_sh;
  logic [BIN_W:0]     w_result;
`ifdef BCD_SIGN_EN
  logic               r_sign, w_sign_next;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_i[4*d +: 4] > 4'd9) w_bad_digit = 1'b1;
    end
  end

  // One step of reverse double-dabble: shift right, then pull each digit back into range.
  assign w_cat    = {r_bcd, r_bin} >> 1;
  assign w_bin_sh = w_cat[BIN_W-1:0];

  always_comb begin
    w_bcd_corr = w_cat[BCD_W+BIN_W-1:BIN_W];
    for (int d = 0; d < DIGITS; d++) begin
      if (w_bcd_corr[4*d +: 4] >= 4'd8) w_bcd_corr[4*d +: 4] = w_bcd_corr[4*d +: 4] - 4'd3;
    end
  end

`ifdef BCD_SIGN_EN
  always_comb begin
    w_result = {1'b0, w_bin_sh};
    if (r_sign && (w_bin_sh != '0)) w_result = ~{1'b0, w_bin_sh} + (BIN_W+1)'(1);
  end
`else
  assign w_result = {1'b0, w_bin_sh};
`endif

  always_comb begin
    w_state_next   = r_state;
    w_bcd_next     = r_bcd;
    w_bin_next     = r_bin;
    w_cnt_next     = r_cnt;
    w_busy_next    = busy;
    w_valid_next   = 1'b0;
    w_error_next   = error;
    w_binario_next = binario;
`ifdef BCD_SIGN_EN
    w_sign_next    = r_sign;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_bcd_next   = bcd_i;
          w_bin_next   = '0;
          w_cnt_next   = CNT_W'(BIN_W - 1);
          w_busy_next  = 1'b1;
          w_error_next = 1'b0;
`ifdef BCD_SIGN_EN
          w_sign_next  = sign_i;
`endif
          w_state_next = w_bad_digit ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_bcd_next = w_bcd_corr;
        w_bin_next = w_bin_sh;
        w_cnt_next = r_cnt - CNT_W'(1);
        if (r_cnt == '0) begin
          w_cnt_next     = '0;
          w_binario_next = w_result;
          w_valid_next   = 1'b1;
          w_error_next   = 1'b0;
          w_state_next   = S_DONE;
        end
      end
      S_DONE: begin
        // Arriving with valid low means the invalid-digit path: strobe the error now.
        if (valid) begin
          w_busy_next  = 1'b0;
          w_state_next = S_IDLE;
        end else begin
          w_valid_next   = 1'b1;
          w_error_next   = 1'b1;
          w_binario_next = '0;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_bcd   <= '0;
      r_bin   <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      error   <= 1'b0;
      binario <= '0;
`ifdef BCD_SIGN_EN
      r_sign  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_bcd   <= w_bcd_next;
      r_bin   <= w_bin_next;
      r_cnt   <= w_cnt_next;
      busy    <= w_busy_next;
      valid   <= w_valid_next;
      error   <= w_error_next;
      binario <= w_binario_next;
`ifdef BCD_SIGN_EN
      r_sign  <= w_sign_next;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: latency-level behavioural model plus directed vectors.
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [4*DIGITS-1:0] bcd_i = '0;
  logic                sign_tb = 1'b0;
  logic                busy, valid, error;
  logic [BIN_W:0]      binario;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_i   (bcd_i),
`ifdef BCD_SIGN_EN
    .sign_i  (sign_tb),
`endif
    .busy    (busy),
    .valid   (valid),
    .error   (error),
    .binario (binario)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Model: decimal value by plain arithmetic, completion after a fixed latency.
  logic m_busy = 1'b0, m_valid = 1'b0, m_error = 1'b0, m_perr = 1'b0;
  int   m_bin = 0, m_pval = 0, m_left = 0;

  function automatic int bcd_value(input logic [15:0] w, output logic bad);
    int v = 0;
    logic [3:0] nib;
    bad = 1'b0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      nib = w[4*d +: 4];
      if (nib > 4'd9) bad = 1'b1;
      v = v * 10 + int'(nib);
    end
    return v;
  endfunction

  always @(posedge clk) begin
    logic bad;
    int   v;
    if (rst) begin
      m_busy = 0; m_valid = 0; m_error = 0; m_bin = 0; m_left = 0;
    end else if (m_valid) begin
      m_valid = 0; m_busy = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_valid = 1;
        m_error = m_perr;
        m_bin   = m_perr ? 0 : m_pval;
      end
    end else if (start) begin
      v = bcd_value(bcd_i, bad);
`ifdef BCD_SIGN_EN
      if (sign_tb && v != 0) v = (1 << (BIN_W + 1)) - v;
`endif
      m_busy = 1; m_error = 0; m_perr = bad; m_pval = v;
      m_left = bad ? 1 : BIN_W;
    end
  end

  always @(negedge clk) begin
    check("cyc_busy",    int'(busy),    int'(m_busy));
    check("cyc_valid",   int'(valid),   int'(m_valid));
    check("cyc_error",   int'(error),   int'(m_error));
    check("cyc_binario", int'(binario), m_bin);
  end

  // Caller is #1 past a posedge with the DUT idle; the next edge accepts the start.
  task automatic run_conv(input logic [15:0] bcd, input logic sgn, input int exp_bin,
                          input logic exp_err, input int exp_lat, input string name);
    int cyc = 0;
    bcd_i = bcd; sign_tb = sgn; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_busy_after_start"}, int'(busy), 1);
    while (!valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_latency"}, cyc, exp_lat);
    check({name, "_binario"}, int'(binario), exp_bin);
    check({name, "_error"}, int'(error), int'(exp_err));
    check({name, "_busy_in_valid"}, int'(busy), 1);
    check({name, "_model_pin"}, m_bin, exp_bin);
    @(posedge clk); #1;
    check({name, "_valid_1cyc"}, int'(valid), 0);
    check({name, "_busy_cleared"}, int'(busy), 0);
  endtask

  initial begin
    int pulses;
    int cyc;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_binario", int'(binario), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_conv(16'h9999, 1'b0, 9999, 1'b0, 14, "c9999");
    run_conv(16'h0000, 1'b0, 0,    1'b0, 14, "c0000");
    run_conv(16'h0001, 1'b0, 1,    1'b0, 14, "c0001");
    run_conv(16'h12A4, 1'b0, 0,    1'b1, 1,  "c12A4");
    run_conv(16'h0042, 1'b0, 42,   1'b0, 14, "c0042");

    // Extra starts while busy and a bcd_i change during SHIFT must not disturb 0255.
    pulses = 0;
    bcd_i = 16'h0255; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      start = (n == 5 || n == 14);
      if (n >= 3) bcd_i = 16'h9000;
      @(posedge clk); #1;
      if (valid) begin
        pulses++;
        check("c0255_binario", int'(binario), 255);
      end
    end
    start = 1'b0;
    check("c0255_pulses", pulses, 1);

    // Reset in the middle of a conversion aborts it without a valid strobe.
    bcd_i = 16'h0777; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", int'(busy), 0);
    check("abort_binario", int'(binario), 0);
    rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (valid) pulses++;
    end
    check("abort_no_valid", pulses, 0);
    run_conv(16'h0042, 1'b0, 42, 1'b0, 14, "after_abort");

    // Start held high: back-to-back conversions are spaced by BIN_W+2 edges.
    bcd_i = 16'h0100; start = 1'b1;
    cyc = 0;
    while (!valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("held_first_binario", int'(binario), 100);
    cyc = 0;
    @(posedge clk); #1;
    cyc++;
    while (!valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("held_spacing", cyc, 16);
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;

`ifdef BCD_SIGN_EN
    run_conv(16'h0128, 1'b1, 32640, 1'b0, 14, "neg128");
    run_conv(16'h0000, 1'b1, 0,     1'b0, 14, "neg0");
    run_conv(16'h9999, 1'b0, 9999,  1'b0, 14, "pos9999");
    run_conv(16'h12A4, 1'b1, 0,     1'b1, 1,  "neg_err");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Sequential BCD-to-binary converter, the inverse of the combinational binary-to-BCD converter in the keypad/Booth datapath.
- Turns a packed decimal word (keypad digits, display buffer) into a binary operand for the Booth multiplier and number storage.
- Uses reverse double-dabble: one right shift plus per-digit subtract-3 correction per cycle, under a start/valid handshake matching the multiplier's.

Parameters:
- DIGITS, 4, number of packed BCD digits on bcd_i.
- BIN_W, 14, binary result width and number of shift cycles; must satisfy 2^BIN_W > 10^DIGITS - 1 (14 for 4 digits).

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request conversion; sampled only in IDLE.
- bcd_i  input  4*DIGITS  packed BCD, digit 0 in bits [3:0].
- busy  output  1  high from the accepted start edge until valid is cleared.
- valid  output  1  one-cycle result strobe.
- error  output  1  invalid-digit flag; qualified by valid.
- binario  output  BIN_W+1  result; MSB is the sign bit (0 when feature is off).
- sign_i  input  1  present only with BCD_SIGN_EN: 1 means negative.

Behaviour:
- Reset: on any rst=1 edge, state=IDLE and busy, valid, error, binario and the counter all go to 0. This holds mid-conversion: the operation is aborted with no valid pulse.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1 (edge k):
  - Latch bcd_i into the BCD shift register and clear the binary shift register.
  - Load counter=BIN_W-1, busy=1.
  - If any nibble >9, go to DONE with error pending. Otherwise go to SHIFT.
- SHIFT, each edge:
  - Shift the {bcd, bin} concatenation right by 1.
  - Then, for each BCD nibble independently, subtract 3 if the nibble is >=8.
  - Decrement counter.
  - On the edge where counter==0: write the final binary value into binario, set valid=1, error=0, go to DONE.
  - Latency: valid is first high in the cycle after edge k+BIN_W (edge k+14 for defaults).
- DONE, error path:
  - Entered from IDLE on an invalid digit.
  - The next edge sets valid=1, error=1, binario=0. Latency is 1 cycle.
- DONE, exit: the edge after valid is set clears valid and busy and returns to IDLE.
- valid is exactly one cycle wide.
- binario holds its value until the next accepted start completes or rst.
- error holds until the next accepted start.
- start while busy=1, or in the valid cycle: ignored, not queued.
- start held high continuously: a new conversion is accepted on the first IDLE edge after return.
- bcd_i is not sampled after the load edge; changes during SHIFT have no effect.
- Residual BCD register nonzero after BIN_W shifts is impossible for legal inputs given the BIN_W constraint; no overflow flag.

Optional Feature:
- Macro: BCD_SIGN_EN.
- Defined:
  - sign_i port exists and is latched with bcd_i.
  - On completion, if sign_i=1 and the magnitude is nonzero, binario = two's complement of the magnitude over BIN_W+1 bits. The negation is applied in the same edge as the final shift, so latency is unchanged.
  - Magnitude 0 with sign_i=1 gives 0.
  - On the error path, binario=0 regardless of sign.
- Undefined: no sign_i port; binario[BIN_W] is always 0.

Test Plan:
- bcd_i=16'h9999, start pulse at edge 0 -> busy 1 over edges 0-15; valid high only in the cycle after edge 14; binario=15'd9999 (0x270F); error=0.
- bcd_i=16'h0000 -> valid after 14 cycles, binario=0, error=0; then bcd_i=16'h0001 -> binario=1.
- bcd_i=16'h12A4 -> valid in the cycle after edge 1, error=1, binario=0; then 16'h0042 -> error=0, binario=42.
- bcd_i=16'h0255, start at edge 0, extra start pulses at edges 5 and 14, bcd_i changed to 16'h9000 at edge 3 -> exactly one valid pulse; binario=255.
- Start 16'h0777, rst=1 at edge 7 -> busy=0 and binario=0 from edge 7, no valid. Start 16'h0042 after release -> binario=42 after 14 cycles.
- BCD_SIGN_EN defined:
  - sign_i=1, bcd_i=16'h0128 -> binario=15'h7F80 (-128).
  - sign_i=1, bcd_i=16'h0000 -> binario=0.
  - sign_i=0, bcd_i=16'h9999 -> binario=15'h270F.
